// File: rtl/frame_stream_reader.sv
// Host-side reader for the serial frame link: detects the frame-ready toggle, drives sck,
// samples one bit per rising edge and emits MSB-first packed bytes with their frame addresses.
module frame_stream_reader #(
    parameter int unsigned FRAME_BITS  = 19200,
    parameter int unsigned SCK_HALF    = 6,
    parameter int unsigned LEAD_CYCLES = 16
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        frame_ready_in,
    input  logic        data_in,
    output logic        sck_out,
    output logic [7:0]  byte_data,
    output logic        byte_valid,
    output logic [11:0] byte_addr,
    output logic        frame_start,
    output logic        frame_done,
    output logic        busy,
    output logic        overrun
);

    typedef enum logic [1:0] {StIdle, StLead, StLow, StHigh} state_e;

    // LEAD lasts one cycle less than LEAD_CYCLES: the detection cycle counts toward the hold-low time.
    localparam logic [15:0] LeadLoad   = 16'(LEAD_CYCLES - 2);
    localparam logic [15:0] HalfLoad   = 16'(SCK_HALF - 1);
    localparam logic [14:0] FrameBitsW = 15'(FRAME_BITS);
    localparam logic [11:0] LastAddr   = 12'(FRAME_BITS / 8 - 1);

    state_e      state_q, state_d;
    logic [1:0]  fr_sync_q;
    logic [1:0]  dat_sync_q;
    logic        fr_prev_q;
    logic [15:0] cnt_q, cnt_d;
    logic [14:0] bit_cnt_q, bit_cnt_d;
    logic [11:0] byte_cnt_q, byte_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  byte_data_q;
    logic [11:0] byte_addr_q;
    logic        byte_valid_q;
    logic        frame_done_q;
    logic        overrun_q;

    logic toggle;
    logic sample;
    logic byte_complete;

    assign toggle        = fr_sync_q[1] ^ fr_prev_q;
    assign sample        = (state_q == StHigh) && (cnt_q == 16'd0);
    assign byte_complete = sample && (bit_cnt_q[2:0] == 3'd7);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_cnt_d   = bit_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        shift_d     = shift_q;
        frame_start = 1'b0;
        case (state_q)
            StIdle: begin
                if (toggle) begin
                    state_d     = StLead;
                    cnt_d       = LeadLoad;
                    bit_cnt_d   = 15'd0;
                    byte_cnt_d  = 12'd0;
                    frame_start = 1'b1;
                end
            end
            StLead: begin
                if (cnt_q == 16'd0) begin
                    state_d = StHigh;
                    cnt_d   = HalfLoad;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            StHigh: begin
                if (cnt_q == 16'd0) begin
                    shift_d   = {shift_q[6:0], dat_sync_q[1]};
                    bit_cnt_d = bit_cnt_q + 15'd1;
                    if (byte_complete) begin
                        byte_cnt_d = byte_cnt_q + 12'd1;
                    end
                    state_d = StLow;
                    cnt_d   = HalfLoad;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            StLow: begin
                if (cnt_q == 16'd0) begin
                    if (bit_cnt_q == FrameBitsW) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StHigh;
                        cnt_d   = HalfLoad;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q    <= StIdle;
            fr_sync_q  <= 2'b00;
            dat_sync_q <= 2'b00;
            fr_prev_q  <= 1'b0;
            cnt_q      <= 16'd0;
            bit_cnt_q  <= 15'd0;
            byte_cnt_q <= 12'd0;
            shift_q    <= 8'd0;
        end else begin
            state_q    <= state_d;
            fr_sync_q  <= {fr_sync_q[0], frame_ready_in};
            dat_sync_q <= {dat_sync_q[0], data_in};
            fr_prev_q  <= fr_sync_q[1];
            cnt_q      <= cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            byte_valid_q <= 1'b0;
            byte_data_q  <= 8'd0;
            byte_addr_q  <= 12'd0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            byte_valid_q <= byte_complete;
            if (byte_complete) begin
                byte_data_q <= shift_d;
                byte_addr_q <= byte_cnt_q;
            end
            frame_done_q <= byte_valid_q && (byte_addr_q == LastAddr);
            // A toggle seen in any non-idle state, including the final LOW cycle, is an overrun.
            overrun_q    <= overrun_q | (toggle && (state_q != StIdle));
        end
    end

    assign sck_out    = (state_q == StHigh);
    assign busy       = (state_q != StIdle);
    assign byte_data  = byte_data_q;
    assign byte_valid = byte_valid_q;
    assign byte_addr  = byte_addr_q;
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_frame_stream_reader.sv
// Directed bench for frame_stream_reader using a reduced frame and a behavioural serializer.
module tb_frame_stream_reader;

    localparam int unsigned FrameBits  = 64;
    localparam int unsigned SckHalf    = 4;
    localparam int unsigned LeadCycles = 16;
    localparam int unsigned NumBytes   = FrameBits / 8;

    logic        clk = 1'b0;
    logic        nreset;
    logic        frame_ready_in;
    logic        data_in;
    logic        sck_out;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic [11:0] byte_addr;
    logic        frame_start;
    logic        frame_done;
    logic        busy;
    logic        overrun;

    frame_stream_reader #(
        .FRAME_BITS  (FrameBits),
        .SCK_HALF    (SckHalf),
        .LEAD_CYCLES (LeadCycles)
    ) u_dut (
        .clk            (clk),
        .nreset         (nreset),
        .frame_ready_in (frame_ready_in),
        .data_in        (data_in),
        .sck_out        (sck_out),
        .byte_data      (byte_data),
        .byte_valid     (byte_valid),
        .byte_addr      (byte_addr),
        .frame_start    (frame_start),
        .frame_done     (frame_done),
        .busy           (busy),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int mode = 0;
    int ser_idx = 0;
    int n_start = 0;
    int n_rise = 0;
    int n_bytes = 0;
    int n_done = 0;
    int start_cyc = 0;
    int last_bv_cyc = 0;
    logic sck_prev = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int idx);
        if (mode == 0) return 8'hA5;
        return (idx == 0) ? 8'h81 : 8'h00;
    endfunction

    function automatic logic ser_bit(input int idx);
        logic [7:0] b;
        b = exp_byte(idx / 8);
        return b[7 - (idx % 8)];
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Serializer advances its bit on each sck falling edge.
    always @(negedge sck_out) begin
        ser_idx = ser_idx + 1;
        data_in = ser_bit(ser_idx);
    end

    always @(negedge clk) begin
        if (frame_start) begin
            n_start++;
            start_cyc = cyc;
        end
        if (sck_out && !sck_prev) begin
            n_rise++;
            if (n_rise == 1) check_eq("first_rise_delay", cyc - start_cyc, LeadCycles);
        end
        sck_prev = sck_out;
        if (byte_valid) begin
            check_eq("byte_addr", byte_addr, n_bytes);
            check_eq("byte_data", byte_data, exp_byte(n_bytes));
            n_bytes++;
            last_bv_cyc = cyc;
        end
        if (frame_done) begin
            n_done++;
            check_eq("done_latency", cyc - last_bv_cyc, 1);
        end
    end

    task automatic start_stream(input int m);
        @(negedge clk);
        mode    = m;
        ser_idx = 0;
        data_in = ser_bit(0);
        n_start = 0;
        n_rise  = 0;
        n_bytes = 0;
        n_done  = 0;
        frame_ready_in = ~frame_ready_in;
    endtask

    task automatic wait_done(input string tag);
        int t = 0;
        while (n_done == 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (n_done == 0) check_eq(tag, 0, 1);
        repeat (10) @(negedge clk);
    endtask

    task automatic wait_bytes(input int k, input string tag);
        int t = 0;
        while (n_bytes < k && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (n_bytes < k) check_eq(tag, 0, 1);
    endtask

    task automatic check_frame();
        check_eq("frame_start_count", n_start, 1);
        check_eq("byte_count", n_bytes, NumBytes);
        check_eq("frame_done_count", n_done, 1);
        check_eq("sck_rise_count", n_rise, FrameBits);
        check_eq("busy_after_frame", busy, 0);
    endtask

    initial begin
        nreset = 1'b0;
        frame_ready_in = 1'b0;
        data_in = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("rst_sck", sck_out, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_byte_valid", byte_valid, 0);
        check_eq("rst_byte_data", byte_data, 0);
        check_eq("rst_byte_addr", byte_addr, 0);
        check_eq("rst_frame_start", frame_start, 0);
        check_eq("rst_frame_done", frame_done, 0);
        check_eq("rst_overrun", overrun, 0);
        nreset = 1'b1;

        // Idle with no toggles.
        repeat (1000) @(negedge clk);
        check_eq("idle_rises", n_rise, 0);
        check_eq("idle_starts", n_start, 0);
        check_eq("idle_busy", busy, 0);
        check_eq("idle_sck", sck_out, 0);

        // Frame of 0xA5, toggle 0->1.
        start_stream(0);
        wait_done("timeout_frame_a5");
        check_frame();
        check_eq("overrun_clean", overrun, 0);
        check_eq("byte_data_hold_a5", byte_data, 8'hA5);

        // Bit ordering, toggle 1->0.
        start_stream(1);
        wait_done("timeout_frame_order");
        check_frame();
        check_eq("byte_data_hold_zero", byte_data, 8'h00);

        // Overrun: toggle mid-frame.
        start_stream(0);
        wait_bytes(3, "timeout_overrun_bytes");
        @(negedge clk);
        frame_ready_in = ~frame_ready_in;
        wait_done("timeout_overrun_frame");
        check_frame();
        check_eq("overrun_set", overrun, 1);
        repeat (200) @(negedge clk);
        check_eq("overrun_no_restart", n_start, 1);
        check_eq("overrun_idle", busy, 0);
        check_eq("overrun_sticky", overrun, 1);

        // Reset mid-frame while sck is high.
        start_stream(0);
        wait_bytes(2, "timeout_reset_bytes");
        begin
            int t = 0;
            while (!sck_out && t < 100) begin
                @(negedge clk);
                t++;
            end
            check_eq("sck_high_before_reset", sck_out, 1);
        end
        nreset = 1'b0;
        frame_ready_in = 1'b0;
        #1;
        check_eq("reset_sck_low", sck_out, 0);
        check_eq("reset_busy_low", busy, 0);
        check_eq("reset_overrun_clear", overrun, 0);
        repeat (5) @(negedge clk);
        nreset = 1'b1;
        repeat (30) @(negedge clk);
        check_eq("reset_no_done", n_done, 0);
        check_eq("reset_no_restart", busy, 0);
        start_stream(0);
        wait_done("timeout_after_reset");
        check_frame();
        check_eq("after_reset_overrun", overrun, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/frame_stream_reader.md
Name: frame_stream_reader

Overview:
- Host-side initiator for the FPGA-to-MCU serial frame link. The frame buffer serializer is the responder on this link.
- It detects the frame-ready toggle and generates the serial clock. It shifts in one thresholded bit per pixel, packs the bits MSB-first into bytes, and presents the bytes with addresses.
- It is used as an on-FPGA loopback and verification master. It also acts as the reference model for the MCU firmware reader.

Parameters:
- FRAME_BITS, 19200: pixel bits per frame, which is 160x120. Must be a multiple of 8.
- SCK_HALF, 6: clk cycles per sck half-period. Minimum 4.
- LEAD_CYCLES, 16: clk cycles sck is held low after the toggle is detected and before the first rising edge.

Ports:
- clk  in  1  system clock (48 MHz).
- nreset  in  1  asynchronous active-low reset.
- frame_ready_in  in  1  frame-ready toggle from the serializer. Asynchronous to clk.
- data_in  in  1  serial pixel data from the serializer. Asynchronous to clk.
- sck_out  out  1  serial clock driven to the serializer.
- byte_data  out  8  assembled byte. The first received bit is bit 7.
- byte_valid  out  1  one-cycle strobe; byte_data and byte_addr are valid.
- byte_addr  out  12  byte index within the frame, 0 to FRAME_BITS/8-1.
- frame_start  out  1  one-cycle pulse when a read begins.
- frame_done  out  1  one-cycle pulse after the last byte.
- busy  out  1  high from LEAD through the end of the last bit.
- overrun  out  1  sticky flag. A toggle arrived while busy. Cleared only by reset.

Behaviour:
- Synchronisers:
  - frame_ready_in and data_in each pass through a 2-flop synchroniser.
  - A toggle event is any change of the synchronised frame_ready versus its registered previous value. This means both edges count.
- Reset: all outputs are 0, sck_out is 0, the FSM is in IDLE, and the synchroniser and previous-value flops are 0.
- FSM states: IDLE, LEAD, LOW, HIGH.
  - IDLE:
    - On a toggle event, go to LEAD.
    - Pulse frame_start in the same cycle as the transition.
    - Clear the bit and byte counters.
  - LEAD:
    - sck_out=0, busy=1.
    - After LEAD_CYCLES cycles, go to HIGH.
    - sck_out rises on entry to HIGH.
  - HIGH:
    - sck_out=1 for SCK_HALF cycles.
    - In the last HIGH cycle, sample the synchronised data_in into the shift register (shift left, LSB in).
    - Then go to LOW.
  - LOW:
    - sck_out=0 for SCK_HALF cycles. The serializer advances its bit on the falling edge.
    - Then go to HIGH if bits remain; otherwise go to IDLE.
    - busy drops on entry to IDLE.
- Sampling margin: the sample is taken SCK_HALF cycles after the rising edge. With 2-flop sync latency this is within the stable window when SCK_HALF>=4.
- Byte packing:
  - On every 8th sample, byte_valid pulses in the cycle after the sample.
  - byte_data holds the 8 bits and byte_addr holds the current byte index. byte_addr then increments.
  - byte_data holds its value until the next byte.
- Frame end:
  - After sample FRAME_BITS, byte_valid for the last byte (addr FRAME_BITS/8-1) is asserted.
  - frame_done pulses in the cycle after that byte_valid.
  - The FSM completes the final LOW half and then enters IDLE.
  - Exactly FRAME_BITS rising edges occur per frame.
- Toggle while busy:
  - The read is not restarted or aborted; the current frame completes.
  - overrun is set.
  - The pending event is discarded: previous-value tracking continues, so no read is queued.
- Toggle in the same cycle as return to IDLE: this counts as busy. overrun is set and no new read starts.
- Counters:
  - The bit counter is 15 bits and the byte counter is 12 bits.
  - Neither counter wraps within a frame. Both reset at frame_start.
- Reset mid-frame: sck_out goes low immediately. No frame_done is issued. The next toggle after reset starts a fresh frame at addr 0.

Test Plan:
- Reset then idle:
  - Stimulus: hold nreset low, release, no toggles for 1000 cycles.
  - Required: all outputs 0 and sck_out remains 0.
- Single frame, pattern 0xA5 repeated:
  - Stimulus: a behavioural serializer that updates on sck falling edges; toggle frame_ready 0->1.
  - Required:
    - frame_start x1.
    - 2400 byte_valid strobes, each with byte_data=0xA5 and addresses 0..2399 in order.
    - frame_done x1, 1 cycle after byte 2399.
    - 19200 sck rising edges.
    - First sck rise exactly LEAD_CYCLES cycles after frame_start.
- Bit ordering:
  - Stimulus: send the first 8 bits as 1,0,0,0,0,0,0,1.
  - Required: byte 0 = 0x81; with a subsequent all-zero stream, bytes 1..2399 = 0x00.
- Toggle on falling edge:
  - Stimulus: a second toggle 1->0 after frame_done.
  - Required: a second complete read occurs and byte_addr restarts at 0.
- Overrun:
  - Stimulus: toggle mid-frame at byte 1000.
  - Required:
    - The frame completes with 2400 bytes.
    - overrun=1 and stays set.
    - No second read starts until the next toggle.
- Reset mid-frame:
  - Stimulus: assert nreset at byte 500, then release and toggle.
  - Required:
    - sck_out is 0 during reset and no frame_done is issued.
    - The new read starts at addr 0.
    - overrun=0.
